// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge.
// Holds the APB master FSM state encoding (3-bit binary, ST_IDLE = 0) and
// the slave-select width, so the AHB slave interface, the APB controller
// and the testbench all agree on them.
package apb_bridge_pkg;

    localparam int SEL_W   = 3;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } apb_state_e;

endpackage

// File: rtl/apb_controller.sv
// APB master sequencer for the AHB-to-APB bridge.
// Takes pipelined AHB transfer info and produces registered APB SETUP/ACCESS
// phases. Back-to-back writes pipeline through WRITEP/WENABLEP.
//
// Ports:
//   Hclk, Hresetn      clock, async active-low reset
//   valid, Hwrite      current AHB transfer request and direction
//   Hwritereg          Hwrite delayed one cycle
//   Haddr_1, Haddr_2   Haddr delayed one / two cycles
//   Hwdata_1           Hwdata delayed one cycle
//   Tempselx           one-hot slave select decoded from Haddr_1
//   Prdata             APB read data
//   Pwrite, Penable, Pselx, Paddr, Pwdata   registered APB outputs
//   Hreadyout          registered AHB ready (low = wait state)
//   Hrdata             combinational copy of Prdata
//
// state        | meaning
// -------------+---------------------------------------------------
// ST_IDLE      | no APB transfer in progress
// ST_WWAIT     | write accepted, waiting one cycle for Hwdata
// ST_READ      | read SETUP phase
// ST_WRITE     | write SETUP phase, no further transfer pending
// ST_WRITEP    | write SETUP phase, another transfer pending
// ST_RENABLE   | read ACCESS phase
// ST_WENABLE   | write ACCESS phase, nothing pending
// ST_WENABLEP  | write ACCESS phase, pending transfer follows
module apb_controller
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              valid,
    input  logic              Hwrite,
    input  logic              Hwritereg,
    input  logic [ADDR_W-1:0] Haddr_1,
    input  logic [ADDR_W-1:0] Haddr_2,
    input  logic [DATA_W-1:0] Hwdata_1,
    input  logic [SEL_W-1:0]  Tempselx,
    input  logic [DATA_W-1:0] Prdata,
    output logic              Pwrite,
    output logic              Penable,
    output logic [SEL_W-1:0]  Pselx,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout,
    output logic [DATA_W-1:0] Hrdata
);

    apb_state_e              state_q, state_d;
    logic                    pwrite_q, pwrite_d;
    logic                    penable_q, penable_d;
    logic [SEL_W-1:0]        pselx_q, pselx_d;
    logic [ADDR_W-1:0]       paddr_q, paddr_d;
    logic [DATA_W-1:0]       pwdata_q, pwdata_d;
    logic                    hreadyout_q, hreadyout_d;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q     <= ST_IDLE;
            pwrite_q    <= 1'b0;
            penable_q   <= 1'b0;
            pselx_q     <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            hreadyout_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            penable_q   <= penable_d;
            pselx_q     <= pselx_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (!valid)      state_d = ST_IDLE;
                else if (Hwrite) state_d = ST_WWAIT;
                else             state_d = ST_READ;
            end
            ST_WWAIT:    state_d = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:     state_d = ST_RENABLE;
            ST_WRITE:    state_d = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:   state_d = ST_WENABLEP;
            ST_WENABLEP: begin
                if (!Hwritereg)  state_d = ST_READ;
                else if (!valid) state_d = ST_WRITE;
                else             state_d = ST_WRITEP;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they are valid
    // in the same cycle as the new state.
    always_comb begin
        pwrite_d    = pwrite_q;
        penable_d   = penable_q;
        pselx_d     = pselx_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        hreadyout_d = hreadyout_q;
        case (state_d)
            ST_IDLE: begin
                pselx_d     = '0;
                penable_d   = 1'b0;
                pwrite_d    = 1'b0;
                hreadyout_d = 1'b1;
            end
            ST_WWAIT: begin
                pselx_d     = '0;
                penable_d   = 1'b0;
                hreadyout_d = 1'b1;
            end
            ST_READ: begin
                paddr_d     = Haddr_1;
                pwrite_d    = 1'b0;
                pselx_d     = Tempselx;
                penable_d   = 1'b0;
                hreadyout_d = 1'b0;
            end
            ST_WRITE, ST_WRITEP: begin
                // Write address is two cycles old: data phase lags address.
                paddr_d     = Haddr_2;
                pwdata_d    = Hwdata_1;
                pwrite_d    = 1'b1;
                pselx_d     = Tempselx;
                penable_d   = 1'b0;
                hreadyout_d = 1'b0;
            end
            ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                penable_d   = 1'b1;
                hreadyout_d = 1'b1;
            end
            default: begin
                pselx_d     = '0;
                penable_d   = 1'b0;
                hreadyout_d = 1'b1;
            end
        endcase
    end

    assign Pwrite    = pwrite_q;
    assign Penable   = penable_q;
    assign Pselx     = pselx_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Hreadyout = hreadyout_q;
    assign Hrdata    = Prdata;

endmodule

// File: tb/tb_apb_controller.sv
module tb_apb_controller;
    import apb_bridge_pkg::*;

    logic        Hclk;
    logic        Hresetn;
    logic        valid;
    logic        Hwrite;
    logic        Hwritereg;
    logic [31:0] Haddr_1;
    logic [31:0] Haddr_2;
    logic [31:0] Hwdata_1;
    logic [2:0]  Tempselx;
    logic [31:0] Prdata;
    logic        Pwrite;
    logic        Penable;
    logic [2:0]  Pselx;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Hreadyout;
    logic [31:0] Hrdata;

    int total = 0;
    int bad   = 0;

    apb_controller #(.ADDR_W(32), .DATA_W(32)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid), .Hwrite(Hwrite),
        .Hwritereg(Hwritereg), .Haddr_1(Haddr_1), .Haddr_2(Haddr_2),
        .Hwdata_1(Hwdata_1), .Tempselx(Tempselx), .Prdata(Prdata),
        .Pwrite(Pwrite), .Penable(Penable), .Pselx(Pselx), .Paddr(Paddr),
        .Pwdata(Pwdata), .Hreadyout(Hreadyout), .Hrdata(Hrdata)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    logic       wv [8];
    logic       wreg [8];
    apb_state_e wst [8];
    int         pen_cnt;

    initial begin
        Hresetn = 1'b0; valid = 1'b0; Hwrite = 1'b0; Hwritereg = 1'b0;
        Haddr_1 = '0; Haddr_2 = '0; Hwdata_1 = '0; Tempselx = '0; Prdata = '0;
        step(); step();
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("rst_pselx", 32'(Pselx), 32'd0);
        chk("rst_penable", 32'(Penable), 32'd0);
        chk("rst_pwrite", 32'(Pwrite), 32'd0);
        chk("rst_paddr", Paddr, 32'd0);
        chk("rst_pwdata", Pwdata, 32'd0);
        chk("rst_hready", 32'(Hreadyout), 32'd1);
        Hresetn = 1'b1;

        // idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_pselx", 32'(Pselx), 32'd0);
            chk("idle_penable", 32'(Penable), 32'd0);
            chk("idle_hready", 32'(Hreadyout), 32'd1);
        end

        // single read
        valid = 1'b1; Hwrite = 1'b0; Haddr_1 = 32'h8000_0010; Tempselx = 3'b001; Prdata = 32'd25;
        step();
        valid = 1'b0;
        chk("rd_state_setup", 32'(dut.state_q), 32'(ST_READ));
        chk("rd_pselx", 32'(Pselx), 32'h1);
        chk("rd_paddr", Paddr, 32'h8000_0010);
        chk("rd_pwrite", 32'(Pwrite), 32'd0);
        chk("rd_penable_setup", 32'(Penable), 32'd0);
        chk("rd_hready_setup", 32'(Hreadyout), 32'd0);
        chk("rd_hrdata", Hrdata, 32'd25);
        step();
        chk("rd_state_access", 32'(dut.state_q), 32'(ST_RENABLE));
        chk("rd_penable_access", 32'(Penable), 32'd1);
        chk("rd_hready_access", 32'(Hreadyout), 32'd1);
        chk("rd_pselx_access", 32'(Pselx), 32'h1);
        chk("rd_paddr_access", Paddr, 32'h8000_0010);
        step();
        chk("rd_state_end", 32'(dut.state_q), 32'(ST_IDLE));
        chk("rd_penable_end", 32'(Penable), 32'd0);
        chk("rd_pselx_end", 32'(Pselx), 32'd0);
        Prdata = 32'h1234_5678;
        #1;
        chk("hrdata_comb", Hrdata, 32'h1234_5678);

        // read with no slave selected: still sequences, Pselx stays 0
        valid = 1'b1; Hwrite = 1'b0; Haddr_1 = 32'h0000_0040; Tempselx = 3'b000;
        step();
        valid = 1'b0;
        chk("nosel_state", 32'(dut.state_q), 32'(ST_READ));
        chk("nosel_pselx", 32'(Pselx), 32'd0);
        step();
        chk("nosel_state2", 32'(dut.state_q), 32'(ST_RENABLE));
        chk("nosel_pselx2", 32'(Pselx), 32'd0);
        step();

        // reset in the middle of a read ACCESS phase
        valid = 1'b1; Hwrite = 1'b0; Haddr_1 = 32'h8000_0020; Tempselx = 3'b100;
        step();
        valid = 1'b0;
        step();
        chk("mid_state_pre", 32'(dut.state_q), 32'(ST_RENABLE));
        Hresetn = 1'b0;
        #1;
        chk("mid_penable", 32'(Penable), 32'd0);
        chk("mid_pselx", 32'(Pselx), 32'd0);
        chk("mid_paddr", Paddr, 32'd0);
        chk("mid_hready", 32'(Hreadyout), 32'd1);
        chk("mid_state", 32'(dut.state_q), 32'(ST_IDLE));
        step();
        chk("mid_state_next", 32'(dut.state_q), 32'(ST_IDLE));
        chk("mid_penable_next", 32'(Penable), 32'd0);
        Hresetn = 1'b1;
        step();

        // single write
        valid = 1'b1; Hwrite = 1'b1;
        step();
        chk("wr_state_wwait", 32'(dut.state_q), 32'(ST_WWAIT));
        chk("wr_hready_wwait", 32'(Hreadyout), 32'd1);
        chk("wr_pselx_wwait", 32'(Pselx), 32'd0);
        valid = 1'b0; Hwrite = 1'b0; Hwritereg = 1'b1;
        Haddr_2 = 32'h8400_0004; Hwdata_1 = 32'hDEAD_BEEF; Tempselx = 3'b010;
        step();
        chk("wr_state_setup", 32'(dut.state_q), 32'(ST_WRITE));
        chk("wr_pwrite", 32'(Pwrite), 32'd1);
        chk("wr_pwdata", Pwdata, 32'hDEAD_BEEF);
        chk("wr_paddr", Paddr, 32'h8400_0004);
        chk("wr_pselx", 32'(Pselx), 32'h2);
        chk("wr_penable_setup", 32'(Penable), 32'd0);
        chk("wr_hready_setup", 32'(Hreadyout), 32'd0);
        Hwritereg = 1'b0;
        step();
        chk("wr_state_access", 32'(dut.state_q), 32'(ST_WENABLE));
        chk("wr_penable_access", 32'(Penable), 32'd1);
        chk("wr_hready_access", 32'(Hreadyout), 32'd1);
        chk("wr_pwdata_hold", Pwdata, 32'hDEAD_BEEF);
        step();
        chk("wr_state_end", 32'(dut.state_q), 32'(ST_IDLE));
        chk("wr_pwrite_end", 32'(Pwrite), 32'd0);

        // three back-to-back writes
        wv   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        wreg = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        wst  = '{ST_WWAIT, ST_WRITEP, ST_WENABLEP, ST_WRITEP,
                 ST_WENABLEP, ST_WRITE, ST_WENABLE, ST_IDLE};
        pen_cnt = 0;
        Tempselx = 3'b010;
        for (int i = 0; i < 8; i++) begin
            valid = wv[i]; Hwrite = wv[i]; Hwritereg = wreg[i];
            Haddr_2 = 32'h1000_0000 + 32'(i * 4);
            Hwdata_1 = 32'hA5A5_0000 + 32'(i);
            step();
            chk("b2b_state", 32'(dut.state_q), 32'(wst[i]));
            if (wst[i] == ST_WRITEP || wst[i] == ST_WRITE) begin
                chk("b2b_paddr", Paddr, 32'h1000_0000 + 32'(i * 4));
                chk("b2b_pwdata", Pwdata, 32'hA5A5_0000 + 32'(i));
                chk("b2b_hready", 32'(Hreadyout), 32'd0);
            end
            if (Penable) pen_cnt++;
        end
        chk("b2b_penable_pulses", 32'(pen_cnt), 32'd3);

        // write followed directly by a read
        valid = 1'b1; Hwrite = 1'b1; Hwritereg = 1'b0;
        step();
        chk("wr2rd_wwait", 32'(dut.state_q), 32'(ST_WWAIT));
        valid = 1'b1; Hwrite = 1'b0; Hwritereg = 1'b1;
        Haddr_2 = 32'h2000_0008; Hwdata_1 = 32'h0BAD_F00D; Tempselx = 3'b010;
        step();
        chk("wr2rd_writep", 32'(dut.state_q), 32'(ST_WRITEP));
        chk("wr2rd_wpaddr", Paddr, 32'h2000_0008);
        valid = 1'b0; Hwrite = 1'b0;
        step();
        chk("wr2rd_wenablep", 32'(dut.state_q), 32'(ST_WENABLEP));
        Hwritereg = 1'b0; Haddr_1 = 32'h3000_000C; Tempselx = 3'b100;
        step();
        chk("wr2rd_read", 32'(dut.state_q), 32'(ST_READ));
        chk("wr2rd_paddr", Paddr, 32'h3000_000C);
        chk("wr2rd_pwrite", 32'(Pwrite), 32'd0);
        chk("wr2rd_pselx", 32'(Pselx), 32'h4);
        chk("wr2rd_pwdata_hold", Pwdata, 32'h0BAD_F00D);
        step();
        chk("wr2rd_renable", 32'(dut.state_q), 32'(ST_RENABLE));
        chk("wr2rd_penable", 32'(Penable), 32'd1);
        step();
        chk("wr2rd_idle", 32'(dut.state_q), 32'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_controller.md
# apb_controller

Bridge-side APB master state machine that sits directly upstream of the APB master interface. It takes the pipelined AHB transfer information (valid, direction, delayed address/data, decoded slave select) and sequences APB SETUP and ACCESS phases. It drives Pwrite/Penable/Pselx/Paddr/Pwdata into the interface and returns Hreadyout and Hrdata to the AHB side.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- Hclk  input  1  single clock; all state updates on the rising edge
- Hresetn  input  1  asynchronous, active-low reset
- valid  input  1  AHB slave decoded a NONSEQ/SEQ transfer to an APB slave this cycle
- Hwrite  input  1  direction of the current AHB transfer
- Hwritereg  input  1  Hwrite delayed one cycle
- Haddr_1  input  ADDR_W  Haddr delayed one cycle
- Haddr_2  input  ADDR_W  Haddr delayed two cycles
- Hwdata_1  input  DATA_W  Hwdata delayed one cycle
- Tempselx  input  3  one-hot APB slave select decoded from Haddr_1
- Prdata  input  DATA_W  read data returned from the APB interface
- Pwrite  output  1  registered APB direction
- Penable  output  1  registered APB enable
- Pselx  output  3  registered APB slave select
- Paddr  output  ADDR_W  registered APB address
- Pwdata  output  DATA_W  registered APB write data
- Hreadyout  output  1  registered AHB ready; low inserts a wait state
- Hrdata  output  DATA_W  combinational copy of Prdata

## Operation
- States: ST_IDLE, ST_WWAIT, ST_READ, ST_WRITE, ST_WRITEP, ST_RENABLE, ST_WENABLE, ST_WENABLEP.
- Transitions:
  - IDLE, RENABLE, WENABLE: !valid -> IDLE; valid&Hwrite -> WWAIT; valid&!Hwrite -> READ.
  - WWAIT: !valid -> WRITE; valid -> WRITEP.
  - READ -> RENABLE (unconditional).
  - WRITE: !valid -> WENABLE; valid -> WENABLEP.
  - WRITEP -> WENABLEP (unconditional).
  - WENABLEP: !Hwritereg -> READ; Hwritereg&!valid -> WRITE; Hwritereg&valid -> WRITEP.
- Outputs are registered and take the values below on the edge that enters the state:
  - IDLE: Pselx=0, Penable=0, Pwrite=0, Hreadyout=1; Paddr/Pwdata held.
  - WWAIT: Pselx=0, Penable=0, Hreadyout=1; address/data being captured upstream.
  - READ: Paddr=Haddr_1, Pwrite=0, Pselx=Tempselx, Penable=0, Hreadyout=0.
  - WRITE/WRITEP: Paddr=Haddr_2, Pwdata=Hwdata_1, Pwrite=1, Pselx=Tempselx, Penable=0, Hreadyout=0.
  - RENABLE/WENABLE/WENABLEP: Penable=1, Hreadyout=1; Paddr/Pwdata/Pwrite/Pselx held.
- Hrdata = Prdata at all times. There is no registering and no gating.
- Pselx is never nonzero while Tempselx=0. If valid is high with Tempselx=0, the block still sequences, and Pselx=0.

## Timing
- Reset (Hresetn low, asynchronous): state=ST_IDLE, Pwrite=0, Penable=0, Pselx=0, Paddr=0, Pwdata=0, Hreadyout=1. Reset asserted mid-transfer aborts immediately, with no completion of the ACCESS phase.
- Single read: valid&!Hwrite at edge N leads to READ at N+1 (SETUP), RENABLE at N+2 (ACCESS, Hreadyout=1). Hreadyout is low for exactly one cycle.
- Single write: valid&Hwrite at edge N leads to WWAIT at N+1, WRITE at N+2 (SETUP, Hreadyout=0), WENABLE at N+3.
- Penable is high for exactly one cycle per transfer and is always preceded by one SETUP cycle carrying the same Pselx/Paddr/Pwrite.
- Back-to-back writes pipeline through WRITEP/WENABLEP: two cycles per write after the first, with no IDLE in between.
- A write followed by a read exits WENABLEP directly into READ.

## Structure
- Shared package apb_bridge_pkg holds the state encoding localparams (3-bit binary, ST_IDLE=0) and the slave-select widths. The AHB slave interface and the testbench reuse them.
- One module, with no sub-module: a state register, next-state logic and an output register block.

## Test plan
- Reset mid-transfer: assert Hresetn=0 during RENABLE -> all outputs 0, Hreadyout=1, state IDLE next edge.
- Single read, Haddr_1=0x8000_0010, Tempselx=3'b001: Pselx=001, Paddr=0x8000_0010, Pwrite=0 on the SETUP cycle; Penable=1 the next cycle; Hreadyout low for 1 cycle; Hrdata equals Prdata (25).
- Single write, Haddr_2=0x8400_0004, Hwdata_1=0xDEAD_BEEF: WWAIT, then WRITE with Pwrite=1 and Pwdata=0xDEAD_BEEF, then WENABLE with Penable=1.
- Three back-to-back writes: state sequence WWAIT, WRITEP, WENABLEP, WRITEP, WENABLEP, WRITE, WENABLE, IDLE; exactly 3 Penable pulses.
- Write then read (Hwritereg=0 in WENABLEP): WENABLEP goes directly to READ, and Paddr switches to the read address.
- Idle with valid=0 for 10 cycles: Pselx=0, Penable=0 and Hreadyout=1 throughout.
